// File: rtl/im_loader_if.sv
// Byte-stream in, IM write port out, plus load control/status for im_loader.
// The slave modport is the loader itself; master is the boot source / system side.
interface im_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [31:0]       im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata, busy, done, err, cpu_hold
    );

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/im_loader.sv
// Packs a valid/ready byte stream into 32-bit words and writes them sequentially
// into the instruction RAM, holding the CPU until the last word lands.
module im_loader #(
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] BASE_BYTE  = 32'h0000_0000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    im_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    state_t          state_r;
    logic [ADDR_W:0] count_r;
    logic [ADDR_W:0] index_r;
    logic [1:0]      byte_cnt_r;
    logic [31:0]     shift_r;
    logic            byte_ready_r;
    logic            im_we_r;
    logic [31:0]     im_addr_r;
    logic [31:0]     im_wdata_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic            cpu_hold_r;

    logic            xfer_s;
    logic [31:0]     shift_s;

    function automatic logic [31:0] pack_byte(input logic [31:0] acc, input logic [7:0] b);
        if (BIG_ENDIAN) begin
            pack_byte = {acc[23:0], b};
        end else begin
            pack_byte = {b, acc[31:8]};
        end
    endfunction

    // Byte handshake and the assembly word including the byte on the bus.
    always_comb begin
        xfer_s  = 1'b0;
        shift_s = pack_byte(shift_r, bus.byte_data);
        if ((state_r == RECV) && byte_ready_r && bus.byte_valid) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
    end

    // Load sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            count_r      <= '0;
            index_r      <= '0;
            byte_cnt_r   <= 2'd0;
            shift_r      <= 32'h0000_0000;
            byte_ready_r <= 1'b0;
            im_we_r      <= 1'b0;
            im_addr_r    <= BASE_BYTE;
            im_wdata_r   <= 32'h0000_0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            cpu_hold_r   <= 1'b0;
        end else begin
            im_we_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        count_r    <= bus.word_count;
                        index_r    <= '0;
                        byte_cnt_r <= 2'd0;
                        shift_r    <= 32'h0000_0000;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                        if (bus.word_count == '0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else if (bus.word_count > MAX_WORDS) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            state_r      <= RECV;
                            byte_ready_r <= 1'b1;
                            busy_r       <= 1'b1;
                            cpu_hold_r   <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (xfer_s) begin
                        shift_r    <= shift_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            state_r      <= WRITE;
                            byte_ready_r <= 1'b0;
                            im_we_r      <= 1'b1;
                            im_wdata_r   <= shift_s;
                            im_addr_r    <= BASE_BYTE + (32'(index_r) << 2);
                        end
                    end
                end
                WRITE: begin
                    index_r <= index_r + ONE;
                    if ((index_r + ONE) == count_r) begin
                        state_r    <= DONE;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        cpu_hold_r <= 1'b0;
                    end else begin
                        state_r      <= RECV;
                        byte_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    byte_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    cpu_hold_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.im_we      = im_we_r;
    assign bus.im_addr    = im_addr_r;
    assign bus.im_wdata   = im_wdata_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.cpu_hold   = cpu_hold_r;
endmodule

// File: tb/tb_im_loader.sv
// Three loaders (BE/base 0, BE/base 0x3000, LE/base 0) driven in lockstep by one
// stimulus stream; every logged write is compared with words built from the sent bytes.
`timescale 1ns/1ps
module tb_im_loader;
    localparam int ADDR_W = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [ADDR_W:0] word_count;
    logic            byte_valid;
    logic [7:0]      byte_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] base_of [3];
    bit          be_of [3];
    logic [7:0]  tx [0:4095];
    int          snap [3];

    logic [31:0] wa [3][0:2047];
    logic [31:0] wd [3][0:2047];
    logic        wr [3][0:2047];
    int          wn [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    im_loader_if #(.ADDR_W(ADDR_W)) b0 ();
    im_loader_if #(.ADDR_W(ADDR_W)) b1 ();
    im_loader_if #(.ADDR_W(ADDR_W)) b2 ();

    assign b0.start = start;  assign b0.word_count = word_count;
    assign b0.byte_valid = byte_valid;  assign b0.byte_data = byte_data;
    assign b1.start = start;  assign b1.word_count = word_count;
    assign b1.byte_valid = byte_valid;  assign b1.byte_data = byte_data;
    assign b2.start = start;  assign b2.word_count = word_count;
    assign b2.byte_valid = byte_valid;  assign b2.byte_data = byte_data;

    im_loader #(.ADDR_W(ADDR_W), .BASE_BYTE(32'h0000_0000), .BIG_ENDIAN(1'b1))
        dut0 (.clk(clk), .reset(reset), .bus(b0));
    im_loader #(.ADDR_W(ADDR_W), .BASE_BYTE(32'h0000_3000), .BIG_ENDIAN(1'b1))
        dut1 (.clk(clk), .reset(reset), .bus(b1));
    im_loader #(.ADDR_W(ADDR_W), .BASE_BYTE(32'h0000_0000), .BIG_ENDIAN(1'b0))
        dut2 (.clk(clk), .reset(reset), .bus(b2));

    task automatic log_write(input int k, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        if (wn[k] < 2048) begin
            wa[k][wn[k]] = a;
            wd[k][wn[k]] = d;
            wr[k][wn[k]] = rdy;
        end
        wn[k] = wn[k] + 1;
    endtask

    always @(negedge clk) begin
        if (b0.im_we === 1'b1) log_write(0, b0.im_addr, b0.im_wdata, b0.byte_ready);
        if (b1.im_we === 1'b1) log_write(1, b1.im_addr, b1.im_wdata, b1.byte_ready);
        if (b2.im_we === 1'b1) log_write(2, b2.im_addr, b2.im_wdata, b2.byte_ready);
    end

    // Reference: word i is bytes 4i..4i+3 in arrival order, ordered by endianness.
    function automatic logic [31:0] model_word(input int k, input int i);
        logic [7:0] x0, x1, x2, x3;
        x0 = tx[4*i]; x1 = tx[4*i+1]; x2 = tx[4*i+2]; x3 = tx[4*i+3];
        if (be_of[k]) return {x0, x1, x2, x3};
        return {x3, x2, x1, x0};
    endfunction

    task automatic take_snap();
        for (int k = 0; k < 3; k++) snap[k] = wn[k];
    endtask

    task automatic pulse_start(input int wc);
        start = 1'b1;
        word_count = (ADDR_W+1)'(wc);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            byte_data = 8'($urandom);
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data = b;
        forever begin
            @(negedge clk);
            if (b0.byte_ready === 1'b1) break;
            guard++;
            if (guard > 40) begin
                checks++; errors++;
                $display("FAIL send_byte: byte_ready stuck at %b, required 1", b0.byte_ready);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (b0.done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (b0.done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", b0.done, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_load(input string name, input int nwords);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ((wn[k] - snap[k]) != nwords) begin
                errors++;
                $display("FAIL %s count dut%0d: writes=%0d required %0d", name, k, wn[k] - snap[k], nwords);
            end
            for (int i = 0; i < nwords && i < (wn[k] - snap[k]) && (snap[k] + i) < 2048; i++) begin
                checks++;
                if (wa[k][snap[k]+i] !== base_of[k] + 32'(4*i) ||
                    wd[k][snap[k]+i] !== model_word(k, i) || wr[k][snap[k]+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s dut%0d word%0d: addr=%h data=%h rdy=%b required addr=%h data=%h rdy=0",
                             name, k, i, wa[k][snap[k]+i], wd[k][snap[k]+i], wr[k][snap[k]+i],
                             base_of[k] + 32'(4*i), model_word(k, i));
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (b0.byte_ready !== 1'b0 || b0.im_we !== 1'b0 || b0.im_addr !== 32'h0 ||
            b0.im_wdata !== 32'h0 || b0.busy !== 1'b0 || b0.done !== 1'b0 ||
            b0.err !== 1'b0 || b0.cpu_hold !== 1'b0 || b1.im_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL %s: rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b hold=%b addr1=%h required all 0, addr1=00003000",
                     name, b0.byte_ready, b0.im_we, b0.im_addr, b0.im_wdata, b0.busy, b0.done,
                     b0.err, b0.cpu_hold, b1.im_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        tx[0] = 8'h8C; tx[1] = 8'h01; tx[2] = 8'h00; tx[3] = 8'h04;
        take_snap();
        pulse_start(1);
        for (int i = 0; i < 4; i++) send_byte(tx[i], 0);
        byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b0.im_we !== 1'b1 || b0.byte_ready !== 1'b0 || b0.im_addr !== 32'h0 ||
            b0.im_wdata !== 32'h8C01_0004 || b0.done !== 1'b0 || b0.cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL single_write_cycle: we=%b rdy=%b addr=%h data=%h done=%b hold=%b required 1 0 0 8c010004 0 1",
                     b0.im_we, b0.byte_ready, b0.im_addr, b0.im_wdata, b0.done, b0.cpu_hold);
        end
        @(negedge clk);
        checks++;
        if (b0.done !== 1'b1 || b0.cpu_hold !== 1'b0 || b0.busy !== 1'b0 ||
            b0.im_we !== 1'b0 || b0.im_wdata !== 32'h8C01_0004) begin
            errors++;
            $display("FAIL single_done: done=%b hold=%b busy=%b we=%b data=%h required 1 0 0 0 8c010004",
                     b0.done, b0.cpu_hold, b0.busy, b0.im_we, b0.im_wdata);
        end
        @(posedge clk); #1;
        check_load("single", 1);
    endtask

    task automatic test_little_endian();
        tx[0] = 8'h04; tx[1] = 8'h00; tx[2] = 8'h01; tx[3] = 8'h8C;
        take_snap();
        pulse_start(1);
        for (int i = 0; i < 4; i++) send_byte(tx[i], 0);
        byte_valid = 1'b0;
        wait_done(20);
        checks++;
        if (wd[2][snap[2]] !== 32'h8C01_0004) begin
            errors++;
            $display("FAIL little_endian: data=%h required 8c010004", wd[2][snap[2]]);
        end
        check_load("little_endian", 1);
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 5; it++) begin
            int wc;
            wc = int'($urandom_range(1, 6));
            for (int i = 0; i < 4*wc; i++) tx[i] = 8'($urandom);
            take_snap();
            pulse_start(wc);
            for (int i = 0; i < 4*wc; i++) send_byte(tx[i], int'($urandom_range(0, 3)));
            byte_valid = 1'b0;
            wait_done(400);
            check_load("random", wc);
        end
    endtask

    task automatic test_zero_and_overflow();
        take_snap();
        pulse_start(0);
        @(negedge clk);
        checks++;
        if (b0.done !== 1'b1 || b0.err !== 1'b0 || b0.busy !== 1'b0 || b0.cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL zero_count: done=%b err=%b busy=%b hold=%b required 1 0 0 0",
                     b0.done, b0.err, b0.busy, b0.cpu_hold);
        end
        @(posedge clk); #1;
        pulse_start(1025);
        byte_valid = 1'b1; byte_data = 8'hA5;
        @(negedge clk);
        checks++;
        if (b0.done !== 1'b1 || b0.err !== 1'b1 || b0.byte_ready !== 1'b0 || b0.cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL overflow: done=%b err=%b rdy=%b hold=%b required 1 1 0 0",
                     b0.done, b0.err, b0.byte_ready, b0.cpu_hold);
        end
        repeat (4) @(posedge clk);
        #1; byte_valid = 1'b0;
        check_load("zero_overflow", 0);
        for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
        take_snap();
        pulse_start(1);
        @(negedge clk);
        checks++;
        if (b0.err !== 1'b0 || b0.done !== 1'b0 || b0.busy !== 1'b1 || b0.cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears: err=%b done=%b busy=%b hold=%b required 0 0 1 1",
                     b0.err, b0.done, b0.busy, b0.cpu_hold);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_byte(tx[i], 0);
        byte_valid = 1'b0;
        wait_done(20);
        check_load("after_err", 1);
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
        take_snap();
        pulse_start(3);
        for (int i = 0; i < 6; i++) send_byte(tx[i], 0);
        byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_midload");
        checks++;
        if ((wn[0] - snap[0]) != 1) begin
            errors++;
            $display("FAIL reset_midload_writes: writes=%0d required 1", wn[0] - snap[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
        take_snap();
        pulse_start(1);
        for (int i = 0; i < 4; i++) send_byte(tx[i], int'($urandom_range(0, 2)));
        byte_valid = 1'b0;
        wait_done(40);
        check_load("after_reset", 1);
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
        take_snap();
        pulse_start(2);
        for (int i = 0; i < 2; i++) send_byte(tx[i], 0);
        byte_valid = 1'b0;
        pulse_start(5);
        for (int i = 2; i < 8; i++) send_byte(tx[i], int'($urandom_range(0, 1)));
        byte_valid = 1'b0;
        wait_done(40);
        check_load("start_ignored", 2);
    endtask

    task automatic test_full_load();
        for (int i = 0; i < 4096; i++) tx[i] = 8'($urandom);
        take_snap();
        pulse_start(1024);
        for (int i = 0; i < 4096; i++) send_byte(tx[i], 0);
        byte_valid = 1'b0;
        wait_done(20);
        check_load("full", 1024);
        checks++;
        if (b0.im_addr !== 32'h0000_0FFC || b1.im_addr !== 32'h0000_3FFC) begin
            errors++;
            $display("FAIL full_last_addr: addr0=%h addr1=%h required 00000ffc 00003ffc",
                     b0.im_addr, b1.im_addr);
        end
    endtask

    initial begin
        base_of[0] = 32'h0000_0000; base_of[1] = 32'h0000_3000; base_of[2] = 32'h0000_0000;
        be_of[0] = 1'b1; be_of[1] = 1'b1; be_of[2] = 1'b0;
        test_reset();
        test_single_word();
        test_little_endian();
        test_random_loads();
        test_zero_and_overflow();
        test_reset_midload();
        test_start_ignored();
        test_full_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
